// File: rtl/ram_param_if.sv
// Bus bundle for ram_param: write data, address, load/clear requests, read data and busy.
// The master drives requests; the slave (the RAM) returns out and busy.
interface ram_param_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] address;
  logic              load;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              busy;

  modport master (
    output in,
    output address,
    output load,
    output clear,
    input  out,
    input  busy
  );

  modport slave (
    input  in,
    input  address,
    input  load,
    input  clear,
    output out,
    output busy
  );
endinterface

// File: rtl/ram_param.sv
// WIDTH x 2^ADDR_W word store with a hardware clear sweep after reset or on request,
// and a selectable combinational (READ_REG=0) or read-first registered (READ_REG=1) read path.
module ram_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned READ_REG = 0
) (
  input logic        clk,
  input logic        rst_n,
  ram_param_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StClear;
      cnt   <= '0;
    end else begin
      unique case (state)
        StClear: begin
          cnt <= cnt + ADDR_W'(1);
          if (&cnt) state <= StIdle;
        end
        StIdle: begin
          if (bus.clear) begin
            state <= StClear;
            cnt   <= '0;
          end
        end
        default: state <= StClear;
      endcase
    end
  end

  // Storage has no reset; while rst_n is low the sweep only rewrites word 0 with zero,
  // which the restarted sweep zeroes first anyway.
  always_ff @(posedge clk) begin
    if (state == StClear) begin
      mem[cnt] <= '0;
    end else if (bus.load && !bus.clear) begin
      mem[bus.address] <= bus.in;
    end
  end

  assign bus.busy = (state == StClear);

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [WIDTH-1:0] out_reg;

      // Read-first: samples storage before this edge's write lands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_reg <= '0;
        end else if (state == StClear) begin
          out_reg <= '0;
        end else begin
          out_reg <= mem[bus.address];
        end
      end

      assign bus.out = out_reg;
    end else begin : g_read_comb
      assign bus.out = (state == StIdle) ? mem[bus.address] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: combinational and registered 16x8 instances share stimulus,
// plus an 8x64 instance for the parametrised sweep and read-back.
module tb_ram_param;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ram_param_if #(.WIDTH(16), .ADDR_W(3)) b0 ();
  ram_param_if #(.WIDTH(16), .ADDR_W(3)) b1 ();
  ram_param_if #(.WIDTH(8),  .ADDR_W(6)) b2 ();

  ram_param #(.WIDTH(16), .ADDR_W(3), .READ_REG(0)) u_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  ram_param #(.WIDTH(16), .ADDR_W(3), .READ_REG(1)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  ram_param #(.WIDTH(8), .ADDR_W(6), .READ_REG(0)) u_wide (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Same request to both 16x8 instances.
  task automatic drive(input logic [2:0] a, input logic [15:0] d, input logic ld,
                       input logic clr);
    b0.address = a;
    b0.in      = d;
    b0.load    = ld;
    b0.clear   = clr;
    b1.address = a;
    b1.in      = d;
    b1.load    = ld;
    b1.clear   = clr;
  endtask

  task automatic read_all_small(input string tag, input logic [15:0] v2, input logic [15:0] v7);
    logic [15:0] exp;
    for (int a = 0; a < 8; a++) begin
      exp = (a == 2) ? v2 : ((a == 7) ? v7 : 16'h0000);
      drive(3'(a), 16'h0000, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (b0.out !== exp) begin
        n_bad++;
        $display("FAIL %s comb addr %0d: got %h, want %h", tag, a, b0.out, exp);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (b1.out !== exp) begin
        n_bad++;
        $display("FAIL %s reg addr %0d: got %h, want %h", tag, a, b1.out, exp);
      end
    end
  endtask

  task automatic sweep_busy(input string tag);
    logic exp;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp = (k < 8);
      n_cmp++;
      if (b0.busy !== exp || b1.busy !== exp) begin
        n_bad++;
        $display("FAIL %s busy after edge %0d: got %b/%b, want %b", tag, k, b0.busy, b1.busy,
                 exp);
      end
      if (k == 8) drive(3'd0, 16'h0000, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(3'd4, 16'hFFFF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (b0.busy !== 1'b1 || b1.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset busy: got %b/%b, want 1/1", b0.busy, b1.busy);
    end
    n_cmp++;
    if (b0.out !== 16'h0000 || b1.out !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset out: got %h/%h, want 0000/0000", b0.out, b1.out);
    end
    rst_n = 1'b1;
    // load stays high through the sweep; nothing may land.
    sweep_busy("reset_sweep");
    read_all_small("reset_read", 16'h0000, 16'h0000);
  endtask

  task automatic test_write_read;
    drive(3'd2, 16'hA5A5, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (b0.out !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL write_same_cycle: got %h, want a5a5", b0.out);
    end
    drive(3'd7, 16'h1234, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    read_all_small("write_read", 16'hA5A5, 16'h1234);
  endtask

  task automatic test_read_first;
    drive(3'd5, 16'h00FF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(3'd5, 16'hBEEF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (b1.out !== 16'h00FF) begin
      n_bad++;
      $display("FAIL read_first old: got %h, want 00ff", b1.out);
    end
    n_cmp++;
    if (b0.out !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL read_first comb: got %h, want beef", b0.out);
    end
    drive(3'd5, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (b1.out !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL read_first new: got %h, want beef", b1.out);
    end
  endtask

  task automatic test_clear_priority;
    logic exp;
    drive(3'd3, 16'h7777, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    n_cmp++;
    if (b0.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_busy_rise: got %b, want 1", b0.busy);
    end
    drive(3'd3, 16'h0000, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp = (k < 8);
      n_cmp++;
      if (b0.busy !== exp || b1.busy !== exp) begin
        n_bad++;
        $display("FAIL clear_busy after edge %0d: got %b/%b, want %b", k, b0.busy, b1.busy,
                 exp);
      end
      if (k == 1) begin
        n_cmp++;
        if (b0.out !== 16'h0000 || b1.out !== 16'h0000) begin
          n_bad++;
          $display("FAIL clear_out_busy: got %h/%h, want 0000/0000", b0.out, b1.out);
        end
      end
      // Second clear mid-sweep must not restart it.
      if (k == 3) drive(3'd3, 16'h0000, 1'b0, 1'b1);
      if (k == 4) drive(3'd3, 16'h0000, 1'b0, 1'b0);
    end
    read_all_small("clear_read", 16'h0000, 16'h0000);
  endtask

  task automatic test_reset_mid_sweep;
    drive(3'd6, 16'hABCD, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(3'd6, 16'h0000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(3'd6, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (b0.busy !== 1'b1 || b1.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset busy: got %b/%b, want 1/1", b0.busy, b1.busy);
    end
    n_cmp++;
    if (b0.out !== 16'h0000 || b1.out !== 16'h0000) begin
      n_bad++;
      $display("FAIL midreset out: got %h/%h, want 0000/0000", b0.out, b1.out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep_busy("midreset_sweep");
    read_all_small("midreset_read", 16'h0000, 16'h0000);
  endtask

  task automatic test_wide;
    int          n;
    logic [7:0]  exp;
    b2.load  = 1'b0;
    b2.clear = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (!b2.busy) break;
    end
    n_cmp++;
    if (n !== 64) begin
      n_bad++;
      $display("FAIL wide_sweep_len: got %0d edges, want 64", n);
    end
    b2.address = 6'd63;
    b2.in      = 8'hC3;
    b2.load    = 1'b1;
    @(posedge clk);
    #1;
    b2.address = 6'd0;
    b2.in      = 8'h3C;
    @(posedge clk);
    #1;
    b2.load = 1'b0;
    for (int a = 0; a < 64; a++) begin
      exp = (a == 63) ? 8'hC3 : ((a == 0) ? 8'h3C : 8'h00);
      b2.address = 6'(a);
      #1;
      n_cmp++;
      if (b2.out !== exp) begin
        n_bad++;
        $display("FAIL wide_read addr %0d: got %h, want %h", a, b2.out, exp);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    b2.in      = 8'h00;
    b2.address = 6'd0;
    b2.load    = 1'b0;
    b2.clear   = 1'b0;
    drive(3'd0, 16'h0000, 1'b0, 1'b0);
    test_reset;
    test_write_read;
    test_read_first;
    test_clear_priority;
    test_reset_mid_sweep;
    test_wide;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
